// File: rtl/boid_plotter.sv
`default_nettype none
// ============================================================================
// Module   : boid_plotter
// Purpose  : Once per frame, walks the boid position memory and draws a
//            SPRITE x SPRITE square of 1-pixels per boid into the back
//            framebuffer. It then issues a one-cycle buffer-swap pulse and
//            waits out a full clear window before it accepts another frame.
// Ports    : clk_i          - system clock, rising edge
//            reset_i        - asynchronous active-high reset
//            frame_tick_i   - one-cycle new-frame request
//            boid_rd_addr_o - boid memory read address (valid in FETCH)
//            boid_x_i/y_i   - boid position, one cycle after the address
//            pix_we_o       - framebuffer write enable
//            pix_addr_o     - framebuffer address py*SCREEN_W+px (0 when idle)
//            pix_data_o     - write data, equal to pix_we_o
//            swap_ram_o     - one-cycle buffer-swap pulse
//            busy_o         - high in every state except IDLE
//            frame_done_o   - one-cycle pulse on the last clear cycle
//            overrun_o      - sticky: frame_tick seen while busy
// Revision : 1.0 - initial release
// ============================================================================
module boid_plotter #(
  parameter int NUM_BOIDS    = 64,
  parameter int BOID_ADDR_W  = 6,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int PIXEL_COUNT  = 307200,
  parameter int PIXEL_ADDR_W = 19,
  parameter int SPRITE       = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    frame_tick_i,
  output logic [BOID_ADDR_W-1:0]  boid_rd_addr_o,
  input  logic [X_W-1:0]          boid_x_i,
  input  logic [Y_W-1:0]          boid_y_i,
  output logic                    pix_we_o,
  output logic [PIXEL_ADDR_W-1:0] pix_addr_o,
  output logic                    pix_data_o,
  output logic                    swap_ram_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    overrun_o
);

  localparam int SPR_W = (SPRITE > 1) ? $clog2(SPRITE) : 1;
  localparam int CLR_W = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;

  localparam logic [SPR_W-1:0]       SPR_LAST = SPR_W'(SPRITE - 1);
  localparam logic [CLR_W-1:0]       CLR_LAST = CLR_W'(PIXEL_COUNT - 1);
  localparam logic [BOID_ADDR_W-1:0] IDX_LAST = BOID_ADDR_W'(NUM_BOIDS - 1);
  localparam logic [X_W:0]           X_LIMIT  = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]           Y_LIMIT  = (Y_W + 1)'(SCREEN_H);
  localparam logic [PIXEL_ADDR_W-1:0] ROW_STRIDE = PIXEL_ADDR_W'(SCREEN_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_PLOT  = 3'd3,
    S_SWAP  = 3'd4,
    S_CLEAR = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [BOID_ADDR_W-1:0] idx_q, idx_d;
  logic [X_W-1:0]         bx_q, bx_d;
  logic [Y_W-1:0]         by_q, by_d;
  logic [SPR_W-1:0]       dx_q, dx_d;
  logic [SPR_W-1:0]       dy_q, dy_d;
  logic [CLR_W-1:0]       clr_q, clr_d;
  logic                   overrun_q, overrun_d;

  // One extra bit on each coordinate so a sprite hanging past the right or
  // bottom edge is recognised as off-screen instead of wrapping to column 0.
  logic [X_W:0]            px;
  logic [Y_W:0]            py;
  logic                    on_screen;
  logic [PIXEL_ADDR_W-1:0] lin_addr;

  assign px        = {1'b0, bx_q} + (X_W + 1)'(dx_q);
  assign py        = {1'b0, by_q} + (Y_W + 1)'(dy_q);
  assign on_screen = (px < X_LIMIT) && (py < Y_LIMIT);
  // Only meaningful when on_screen, where it cannot exceed PIXEL_COUNT-1.
  assign lin_addr  = PIXEL_ADDR_W'(py) * ROW_STRIDE + PIXEL_ADDR_W'(px);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      clr_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      clr_q     <= clr_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    bx_d           = bx_q;
    by_d           = by_q;
    dx_d           = dx_q;
    dy_d           = dy_q;
    clr_d          = clr_q;
    // A tick in any non-idle state (including the last CLEAR cycle) is lost.
    overrun_d      = overrun_q | (frame_tick_i && (state_q != S_IDLE));
    boid_rd_addr_o = '0;
    pix_we_o       = 1'b0;
    pix_addr_o     = '0;
    swap_ram_o     = 1'b0;
    frame_done_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_tick_i) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        boid_rd_addr_o = idx_q;
        state_d        = S_LATCH;
      end

      S_LATCH: begin
        // Memory data for the address issued in FETCH is valid now.
        bx_d    = boid_x_i;
        by_d    = boid_y_i;
        dx_d    = '0;
        dy_d    = '0;
        state_d = S_PLOT;
      end

      S_PLOT: begin
        pix_we_o   = on_screen;
        pix_addr_o = on_screen ? lin_addr : '0;
        if (dx_q == SPR_LAST) begin
          dx_d = '0;
          if (dy_q == SPR_LAST) begin
            dy_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_SWAP;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            dy_d = dy_q + 1'b1;
          end
        end else begin
          dx_d = dx_q + 1'b1;
        end
      end

      S_SWAP: begin
        swap_ram_o = 1'b1;
        clr_d      = '0;
        state_d    = S_CLEAR;
      end

      S_CLEAR: begin
        if (clr_q == CLR_LAST) begin
          frame_done_o = 1'b1;
          clr_d        = '0;
          state_d      = S_IDLE;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pix_data_o = pix_we_o;
  assign busy_o     = (state_q != S_IDLE);
  assign overrun_o  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_boid_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tb_boid_plotter
// Purpose  : Self-checking bench for boid_plotter on an 8x4 screen with two
//            boids and a 2x2 sprite. A table of boid positions with the
//            expected write sequence drives whole frames; extra sequences
//            cover overrun, asynchronous reset mid-frame and read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boid_plotter;

  localparam int NB = 2;
  localparam int AW = 1;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam int PW = 5;

  logic          clk;
  logic          rst;
  logic          frame_tick;
  logic [AW-1:0] boid_rd_addr;
  logic [XW-1:0] boid_x;
  logic [YW-1:0] boid_y;
  logic          pix_we;
  logic [PW-1:0] pix_addr;
  logic          pix_data;
  logic          swap_ram;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  boid_plotter #(
    .NUM_BOIDS    (NB),
    .BOID_ADDR_W  (AW),
    .SCREEN_W     (8),
    .SCREEN_H     (4),
    .X_W          (XW),
    .Y_W          (YW),
    .PIXEL_COUNT  (32),
    .PIXEL_ADDR_W (PW),
    .SPRITE       (2)
  ) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .frame_tick_i   (frame_tick),
    .boid_rd_addr_o (boid_rd_addr),
    .boid_x_i       (boid_x),
    .boid_y_i       (boid_y),
    .pix_we_o       (pix_we),
    .pix_addr_o     (pix_addr),
    .pix_data_o     (pix_data),
    .swap_ram_o     (swap_ram),
    .busy_o         (busy),
    .frame_done_o   (frame_done),
    .overrun_o      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Boid position memory: synchronous read, data one cycle after address.
  logic [XW-1:0] mem_x [NB];
  logic [YW-1:0] mem_y [NB];
  always @(posedge clk) begin
    boid_x <= mem_x[boid_rd_addr];
    boid_y <= mem_y[boid_rd_addr];
  end

  // Boid 0 is preloaded as (px0,py0) and rewritten to (x0,y0) during its
  // FETCH cycle; the sprite must be drawn from (x0,y0).
  typedef struct {
    logic [XW-1:0]      px0;
    logic [YW-1:0]      py0;
    logic [XW-1:0]      x0;
    logic [YW-1:0]      y0;
    logic [XW-1:0]      x1;
    logic [YW-1:0]      y1;
    logic [7:0]         we;    // bit k = write expected in plot slot k
    logic [7:0][PW-1:0] addr;  // element k = address for plot slot k
  } vec_t;

  vec_t vecs [5];

  int n_cmp;
  int n_bad;
  logic ovr_exp;

  task automatic chk(input string nm, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, c, act, exp);
    end
  endtask

  // Starts a frame with a tick in cycle 0 and checks cycles 1..47.
  // tick2 != 0 raises a second tick during that cycle.
  task automatic run_frame(input vec_t v, input int tick2);
    int  slot;
    logic ewe;
    logic [PW-1:0] eaddr;
    mem_x[0] = v.px0;
    mem_y[0] = v.py0;
    mem_x[1] = v.x1;
    mem_y[1] = v.y1;
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 47; c++) begin
      frame_tick = (tick2 != 0) && (c == tick2);
      if (c == 1) begin
        mem_x[0] = v.x0;
        mem_y[0] = v.y0;
      end
      if ((tick2 != 0) && (c == tick2 + 1)) ovr_exp = 1'b1;
      @(negedge clk);
      if (c >= 3 && c <= 6)       slot = c - 3;
      else if (c >= 9 && c <= 12) slot = c - 5;
      else                        slot = -1;
      ewe   = (slot >= 0) ? v.we[slot] : 1'b0;
      eaddr = ewe ? v.addr[slot] : '0;
      chk("pix_we",     c, 32'(pix_we),     32'(ewe));
      chk("pix_data",   c, 32'(pix_data),   32'(ewe));
      chk("pix_addr",   c, 32'(pix_addr),   32'(eaddr));
      chk("swap_ram",   c, 32'(swap_ram),   32'(c == 13));
      chk("frame_done", c, 32'(frame_done), 32'(c == 45));
      chk("busy",       c, 32'(busy),       32'(c <= 45));
      chk("overrun",    c, 32'(overrun),    32'(ovr_exp));
      if (c == 1) chk("rd_addr_b0", c, 32'(boid_rd_addr), 32'd0);
      if (c == 7) chk("rd_addr_b1", c, 32'(boid_rd_addr), 32'd1);
      @(posedge clk);
      #1;
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    ovr_exp    = 1'b0;
    frame_tick = 1'b0;
    rst        = 1'b1;
    for (int i = 0; i < NB; i++) begin
      mem_x[i] = '0;
      mem_y[i] = '0;
    end

    // (1,1),(4,2): basic plot
    vecs[0] = '{px0: 4'd1, py0: 3'd1, x0: 4'd1, y0: 3'd1, x1: 4'd4, y1: 3'd2,
                we: 8'hFF,
                addr: {5'd29, 5'd28, 5'd21, 5'd20, 5'd18, 5'd17, 5'd10, 5'd9}};
    // (7,3) clipped to one pixel, (0,0) top-left corner
    vecs[1] = '{px0: 4'd7, py0: 3'd3, x0: 4'd7, y0: 3'd3, x1: 4'd0, y1: 3'd0,
                we: 8'hF1,
                addr: {5'd9, 5'd8, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31}};
    // (9,5) fully off-screen, (6,2) bottom-right corner
    vecs[2] = '{px0: 4'd9, py0: 3'd5, x0: 4'd9, y0: 3'd5, x1: 4'd6, y1: 3'd2,
                we: 8'hF0,
                addr: {5'd31, 5'd30, 5'd23, 5'd22, 5'd0, 5'd0, 5'd0, 5'd0}};
    // (3,0) top edge, (7,1) clipped on the right
    vecs[3] = '{px0: 4'd3, py0: 3'd0, x0: 4'd3, y0: 3'd0, x1: 4'd7, y1: 3'd1,
                we: 8'h5F,
                addr: {5'd0, 5'd23, 5'd0, 5'd15, 5'd12, 5'd11, 5'd4, 5'd3}};
    // read latency: bus shows (0,0) during FETCH, memory now holds (5,1)
    vecs[4] = '{px0: 4'd0, py0: 3'd0, x0: 4'd5, y0: 3'd1, x1: 4'd0, y1: 3'd2,
                we: 8'hFF,
                addr: {5'd25, 5'd24, 5'd17, 5'd16, 5'd22, 5'd21, 5'd14, 5'd13}};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy",     0, 32'(busy),         32'd0);
    chk("rst_pix_we",   0, 32'(pix_we),       32'd0);
    chk("rst_pix_addr", 0, 32'(pix_addr),     32'd0);
    chk("rst_swap",     0, 32'(swap_ram),     32'd0);
    chk("rst_done",     0, 32'(frame_done),   32'd0);
    chk("rst_overrun",  0, 32'(overrun),      32'd0);
    chk("rst_rd_addr",  0, 32'(boid_rd_addr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 5; k++) run_frame(vecs[k], 0);

    // Second tick five cycles after the first: ignored, overrun sticks.
    run_frame(vecs[1], 5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("overrun_sticky", 0, 32'(overrun), 32'd1);

    // Asynchronous reset during PLOT of boid 0.
    mem_x[0] = 4'd1; mem_y[0] = 3'd1;
    mem_x[1] = 4'd4; mem_y[1] = 3'd2;
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_we",   4, 32'(pix_we),   32'd1);
    chk("pre_rst_addr", 4, 32'(pix_addr), 32'd10);
    #1 rst = 1'b1;
    #1;
    chk("async_busy",    4, 32'(busy),     32'd0);
    chk("async_we",      4, 32'(pix_we),   32'd0);
    chk("async_addr",    4, 32'(pix_addr), 32'd0);
    chk("async_overrun", 4, 32'(overrun),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ovr_exp = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_rst_swap", c, 32'(swap_ram), 32'd0);
      chk("post_rst_busy", c, 32'(busy),     32'd0);
    end

    // A normal frame still runs after the aborted one.
    run_frame(vecs[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
